fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the program ROM. Holds the program counter and drives the ROM address and enable. Captures the 4-bit instruction word the ROM returns and presents it to the decode/execute stage over a valid/ready handshake. Supports PC redirect (jump) on instruction acceptance and end-of-program wrap or halt.

---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage holding the PC, driving the program ROM and
// presenting each fetched word downstream over a valid/ready handshake.
//   clock, reset          : clock and asynchronous active-high reset
//   run                   : level enable for fetching
//   rom_enable, rom_addr  : ROM read enable and address (= pc)
//   rom_data              : ROM word, updated by the ROM on negedge while enabled
//   instr, instr_pc       : captured instruction and the address it came from
//   instr_valid/ready     : downstream handshake
//   jump_valid, jump_addr : redirect request, honoured only on accept
//   halted                : fetch stopped until reset
module fetch_unit #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 4,
    parameter int PROG_LEN   = 7,
    parameter bit WRAP       = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    output logic                  rom_enable,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  halted
);
    typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(PROG_LEN - 1);
    // one extra bit so a program filling the whole address space still compares correctly
    localparam logic [ADDR_WIDTH:0]   LEN  = (ADDR_WIDTH + 1)'(PROG_LEN);

    state_t                  state, state_nx, resume;
    logic [ADDR_WIDTH-1:0]   pc, pc_nx;
    logic                    jump_ok;

    assign jump_ok = {1'b0, jump_addr} < LEN;
    assign resume  = run ? REQ : IDLE;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            IDLE:  state_nx = resume;
            REQ:   state_nx = ISSUE;
            ISSUE: if (instr_ready) begin
                if (jump_valid) begin
                    pc_nx    = jump_ok ? jump_addr : pc;
                    state_nx = jump_ok ? resume : HALT;
                end else if (pc == LAST) begin
                    pc_nx    = WRAP ? '0 : pc;
                    state_nx = WRAP ? resume : HALT;
                end else begin
                    pc_nx    = pc + ADDR_WIDTH'(1);
                    state_nx = resume;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == REQ) begin
                instr    <= rom_data;
                instr_pc <= pc;
            end
        end
    end

    assign rom_enable  = state == REQ;
    assign rom_addr    = pc;
    assign instr_valid = state == ISSUE;
    assign halted      = state == HALT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (wrapping instance plus a halting twin).
module tb_fetch_unit;
    logic       clock = 0, reset = 0, run = 0, instr_ready = 0, jump_valid = 0;
    logic [2:0] jump_addr = 0;
    logic [3:0] rom_data = 0, rom_data_h = 0;
    logic       rom_enable, instr_valid, halted, rom_enable_h, instr_valid_h, halted_h;
    logic [2:0] rom_addr, instr_pc, rom_addr_h, instr_pc_h;
    logic [3:0] instr, instr_h;
    logic [3:0] img [8] = '{4'hA, 4'h3, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h0};
    int         n_cmp = 0, n_err = 0;

    fetch_unit #(.WRAP(1)) dut (
        .clock(clock), .reset(reset), .run(run), .rom_enable(rom_enable), .rom_addr(rom_addr),
        .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_addr(jump_addr), .halted(halted)
    );

    fetch_unit #(.WRAP(0)) dut_h (
        .clock(clock), .reset(reset), .run(run), .rom_enable(rom_enable_h), .rom_addr(rom_addr_h),
        .rom_data(rom_data_h), .instr(instr_h), .instr_pc(instr_pc_h), .instr_valid(instr_valid_h),
        .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_addr(jump_addr), .halted(halted_h)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rom_enable) rom_data <= img[rom_addr];
        if (rom_enable_h) rom_data_h <= img[rom_addr_h];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic exp_req(input string t, input int a);
        check({t, ":en"}, 32'(rom_enable), 1);
        check({t, ":addr"}, 32'(rom_addr), 32'(a));
        check({t, ":valid"}, 32'(instr_valid), 0);
    endtask

    task automatic exp_issue(input string t, input int d, input int a);
        check({t, ":valid"}, 32'(instr_valid), 1);
        check({t, ":instr"}, 32'(instr), 32'(d));
        check({t, ":ipc"}, 32'(instr_pc), 32'(a));
        check({t, ":en"}, 32'(rom_enable), 0);
    endtask

    task automatic exp_idle(input string t, input int a);
        check({t, ":en"}, 32'(rom_enable), 0);
        check({t, ":valid"}, 32'(instr_valid), 0);
        check({t, ":addr"}, 32'(rom_addr), 32'(a));
        check({t, ":halted"}, 32'(halted), 0);
    endtask

    task automatic halt_dut(input string t);
        check({t, ":halted"}, 32'(halted), 1);
        check({t, ":en"}, 32'(rom_enable), 0);
        check({t, ":valid"}, 32'(instr_valid), 0);
    endtask

    task automatic halt_h(input string t);
        check({t, ":halted_h"}, 32'(halted_h), 1);
        check({t, ":en_h"}, 32'(rom_enable_h), 0);
        check({t, ":valid_h"}, 32'(instr_valid_h), 0);
    endtask

    initial begin
        #1 reset = 1;
        #1;
        exp_idle("rst", 0);
        check("rst:instr", 32'(instr), 0);
        check("rst:ipc", 32'(instr_pc), 0);
        repeat (2) step;
        reset = 0;
        run = 1;
        instr_ready = 1;
        for (int i = 0; i < 7; i++) begin
            step;
            exp_req($sformatf("seq%0d", i), i);
            step;
            exp_issue($sformatf("seq%0d", i), int'(img[i]), i);
        end
        step;
        exp_req("wrap", 0);
        halt_h("halt_h0");
        step;
        exp_issue("wrap", 4'hA, 0);
        halt_h("halt_h1");
        step;
        exp_req("pc1", 1);
        jump_valid = 1;
        jump_addr = 4;
        step;
        exp_issue("nojump", 4'h3, 1);
        jump_addr = 5;
        step;
        jump_valid = 0;
        exp_req("jump", 5);
        step;
        exp_issue("jump", 4'h4, 5);
        step;
        exp_req("pc6", 6);
        step;
        exp_issue("pc6", 4'h3, 6);
        step;
        exp_req("pc0b", 0);
        step;
        exp_issue("pc0b", 4'hA, 0);
        step;
        exp_req("pc1b", 1);
        step;
        exp_issue("pc1b", 4'h3, 1);
        step;
        exp_req("pc2", 2);
        step;
        exp_issue("bp0", 4'h7, 2);
        instr_ready = 0;
        for (int k = 0; k < 5; k++) begin
            step;
            exp_issue($sformatf("bp%0d", k + 1), 4'h7, 2);
            check($sformatf("bp%0d:addr", k + 1), 32'(rom_addr), 2);
        end
        instr_ready = 1;
        step;
        exp_req("bp_rel", 3);
        step;
        exp_issue("pc3", 4'h6, 3);
        run = 0;
        instr_ready = 0;
        step;
        exp_issue("run0_hold", 4'h6, 3);
        instr_ready = 1;
        step;
        exp_idle("run0_idle", 4);
        step;
        exp_idle("run0_idle2", 4);
        halt_h("halt_h2");
        run = 1;
        step;
        exp_req("resume", 4);
        step;
        exp_issue("resume", 4'h5, 4);
        step;
        exp_req("pc5b", 5);
        #2 reset = 1;
        #1;
        check("arst:en", 32'(rom_enable), 0);
        check("arst:valid", 32'(instr_valid), 0);
        check("arst:instr", 32'(instr), 0);
        check("arst:ipc", 32'(instr_pc), 0);
        check("arst:addr", 32'(rom_addr), 0);
        check("arst:halted_h", 32'(halted_h), 0);
        step;
        reset = 0;
        step;
        exp_req("rst_req", 0);
        step;
        exp_issue("rst_issue", 4'hA, 0);
        jump_valid = 1;
        jump_addr = 7;
        step;
        jump_valid = 0;
        halt_dut("jhalt0");
        run = 0;
        step;
        halt_dut("jhalt1");
        run = 1;
        step;
        halt_dut("jhalt2");
        step;
        halt_dut("jhalt3");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
